// File: rtl/fir_tap_loader.sv
// fir_tap_loader: shadow coefficient memory plus reload sequencer for the FIR.
// Taps are written while idle; a commit drops the FIR enable for a fixed
// number of cycles and then streams every tap, in index order, over a
// valid/ready port. Commits that arrive mid-reload are remembered and
// trigger exactly one more reload.

module fir_tap_loader #(
    parameter int G_NUM_TAPS_LOG2  = 4,
    parameter int G_TAP_WIDTH      = 16,
    parameter int G_RESTART_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
    input  logic                       cfg_wr_en,
    input  logic                       cfg_commit,
    output logic                       busy,
    output logic                       loaded,
    output logic                       wr_err,
    output logic                       fir_enable,
    output logic [G_TAP_WIDTH-1:0]     tap_dout,
    output logic                       tap_dout_valid,
    input  logic                       tap_dout_ready
);

    localparam int K      = 2 ** G_NUM_TAPS_LOG2;
    localparam int RCNT_W = (G_RESTART_CYCLES > 1) ? $clog2(G_RESTART_CYCLES) : 1;

    localparam logic [RCNT_W-1:0]          RCNT_LAST = RCNT_W'(G_RESTART_CYCLES - 1);
    localparam logic [RCNT_W-1:0]          RCNT_ONE  = RCNT_W'(1);
    localparam logic [G_NUM_TAPS_LOG2-1:0] IDX_LAST  = '1;
    localparam logic [G_NUM_TAPS_LOG2-1:0] IDX_ONE   = G_NUM_TAPS_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTART,
        ST_STREAM
    } state_t;

    // Shadow memory and its write strobe
    logic [G_TAP_WIDTH-1:0] mem [K];
    logic                   mem_we;

    // Registered state and its next-state values
    state_t                     state_q, state_d;
    logic [RCNT_W-1:0]          rcnt_q, rcnt_d;
    logic [G_NUM_TAPS_LOG2-1:0] idx_q, idx_d;
    logic                       pending_q, pending_d;
    logic                       busy_d, loaded_d, wr_err_d, fir_enable_d, valid_d;
    logic [G_TAP_WIDTH-1:0]     tap_dout_d;
    logic [G_NUM_TAPS_LOG2-1:0] idx_inc;

    assign idx_inc = idx_q + IDX_ONE;

    // Shadow write port; only the idle state may modify the tap set.
    // NOTE: the memory has no reset branch on purpose -- contents survive a
    // reset, and a reset on a RAM array would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // State and output registers; every output comes straight from a flop.
    // NOTE: sequential blocks use non-blocking (<=) so all flops update
    // together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rcnt_q         <= '0;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            busy           <= 1'b0;
            loaded         <= 1'b0;
            wr_err         <= 1'b0;
            fir_enable     <= 1'b0;
            tap_dout       <= '0;
            tap_dout_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            rcnt_q         <= rcnt_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            busy           <= busy_d;
            loaded         <= loaded_d;
            wr_err         <= wr_err_d;
            fir_enable     <= fir_enable_d;
            tap_dout       <= tap_dout_d;
            tap_dout_valid <= valid_d;
        end
    end

    // Next-state and next-output decode for the reload sequencer.
    // NOTE: every signal gets a hold/default value first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        busy_d       = busy;
        loaded_d     = loaded;
        wr_err_d     = wr_err;
        fir_enable_d = fir_enable;
        tap_dout_d   = tap_dout;
        valid_d      = tap_dout_valid;
        mem_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A write in the commit cycle lands at the same edge, so it is
                // part of the set that gets streamed.
                mem_we = cfg_wr_en;
                if (cfg_commit) begin
                    state_d      = ST_RESTART;
                    rcnt_d       = '0;
                    busy_d       = 1'b1;
                    loaded_d     = 1'b0;
                    wr_err_d     = 1'b0;
                    fir_enable_d = 1'b0;
                end
            end

            ST_RESTART: begin
                if (cfg_wr_en)  wr_err_d  = 1'b1;
                if (cfg_commit) pending_d = 1'b1;
                if (rcnt_q == RCNT_LAST) begin
                    state_d      = ST_STREAM;
                    idx_d        = '0;
                    tap_dout_d   = mem[0];
                    valid_d      = 1'b1;
                    fir_enable_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RCNT_ONE;
                end
            end

            ST_STREAM: begin
                if (cfg_wr_en)  wr_err_d  = 1'b1;
                if (cfg_commit) pending_d = 1'b1;
                if (tap_dout_valid && tap_dout_ready) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d      = idx_inc;
                        tap_dout_d = mem[idx_inc];
                    end else begin
                        idx_d      = '0;
                        tap_dout_d = '0;
                        valid_d    = 1'b0;
                        // A commit seen anywhere in this reload, including this
                        // very cycle, folds into a single follow-up reload.
                        if (pending_q || cfg_commit) begin
                            state_d      = ST_RESTART;
                            rcnt_d       = '0;
                            pending_d    = 1'b0;
                            fir_enable_d = 1'b0;
                        end else begin
                            state_d  = ST_IDLE;
                            busy_d   = 1'b0;
                            loaded_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed testbench for fir_tap_loader: loads a known tap set and checks
// reload timing, back-pressure handling, dropped writes, queued commits,
// same-cycle write+commit and reset in the middle of a stream.

module tb_fir_tap_loader;

    localparam int LOG2K  = 4;
    localparam int K      = 16;
    localparam int W      = 16;
    localparam int BUDGET = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic [LOG2K-1:0] cfg_wr_addr;
    logic [W-1:0]     cfg_wr_data;
    logic             cfg_wr_en;
    logic             cfg_commit;
    logic             busy;
    logic             loaded;
    logic             wr_err;
    logic             fir_enable;
    logic [W-1:0]     tap_dout;
    logic             tap_dout_valid;
    logic             tap_dout_ready;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_mem [K];
    logic [W-1:0] got_q [$];
    int           en_low;
    int           loaded_at;

    fir_tap_loader #(
        .G_NUM_TAPS_LOG2 (LOG2K),
        .G_TAP_WIDTH     (W),
        .G_RESTART_CYCLES(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_wr_addr   (cfg_wr_addr),
        .cfg_wr_data   (cfg_wr_data),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_commit    (cfg_commit),
        .busy          (busy),
        .loaded        (loaded),
        .wr_err        (wr_err),
        .fir_enable    (fir_enable),
        .tap_dout      (tap_dout),
        .tap_dout_valid(tap_dout_valid),
        .tap_dout_ready(tap_dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue a commit at the next edge and follow the reload cycle by cycle.
    // Inputs change and outputs are sampled on the falling edge. Cycle n is
    // the one following commit edge T0+n-1. The *_at knobs act on the cycle
    // of the given transfer number (1-based); -1 disables them.
    task automatic reload(input bit toggle, input bit wr0, input int commit_at,
                          input int wr_at, input int rst_at);
        int           xfers;
        bit           prev_valid;
        bit           prev_xfer;
        bit           r;
        logic [W-1:0] prev_dout;
        logic [3:0]   pat;
        xfers      = 0;
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        prev_dout  = '0;
        pat        = 4'b1001;
        got_q.delete();
        en_low     = 0;
        loaded_at  = -1;

        cfg_commit = 1'b1;
        if (wr0) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = '0;
            cfg_wr_data = 16'h7FFF;
        end
        @(negedge clk);
        for (int n = 1; n <= BUDGET; n++) begin
            cfg_commit = 1'b0;
            cfg_wr_en  = 1'b0;
            r = toggle ? pat[(n - 1) % 4] : 1'b1;
            tap_dout_ready = r;
            if (!fir_enable) en_low++;
            if (loaded) begin
                loaded_at = n;
                break;
            end
            if (prev_valid && !prev_xfer && tap_dout_valid)
                check("hold_stable", 32'(tap_dout), 32'(prev_dout));
            prev_xfer  = tap_dout_valid && r;
            prev_valid = tap_dout_valid;
            prev_dout  = tap_dout;
            if (prev_xfer) begin
                got_q.push_back(tap_dout);
                xfers++;
                if (xfers == commit_at) cfg_commit = 1'b1;
                if (xfers == wr_at) begin
                    cfg_wr_en   = 1'b1;
                    cfg_wr_addr = 4'd3;
                    cfg_wr_data = 16'hDEAD;
                end
                if (xfers == rst_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    check("rst_valid",  32'(tap_dout_valid), 32'd0);
                    check("rst_enable", 32'(fir_enable),     32'd0);
                    check("rst_busy",   32'(busy),           32'd0);
                    check("rst_loaded", 32'(loaded),         32'd0);
                    reset = 1'b0;
                    return;
                end
            end
            @(negedge clk);
        end
        cfg_commit = 1'b0;
        cfg_wr_en  = 1'b0;
    endtask

    // Compare the captured transfers against reps passes of the tap model.
    task automatic cmp_stream(input string tag, input int reps);
        check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(K * reps));
        for (int i = 0; i < got_q.size() && i < K * reps; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_mem[i % K]));
    endtask

    initial begin
        reset          = 1'b1;
        cfg_wr_addr    = '0;
        cfg_wr_data    = '0;
        cfg_wr_en      = 1'b0;
        cfg_commit     = 1'b0;
        tap_dout_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_fir_enable", 32'(fir_enable),     32'd0);
        check("rst_tap_valid",  32'(tap_dout_valid), 32'd0);
        check("rst_tap_dout",   32'(tap_dout),       32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_loaded",     32'(loaded),         32'd0);
        check("rst_wr_err",     32'(wr_err),         32'd0);
        reset = 1'b0;

        // Load taps k -> 0x0100+k while idle
        for (int k = 0; k < K; k++) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = 4'(k);
            cfg_wr_data = 16'h0100 + 16'(k);
            exp_mem[k]  = 16'h0100 + 16'(k);
            @(negedge clk);
        end
        cfg_wr_en = 1'b0;
        check("idle_busy",   32'(busy),       32'd0);
        check("idle_wr_err", 32'(wr_err),     32'd0);
        check("idle_enable", 32'(fir_enable), 32'd0);

        // Plain reload with ready held high
        reload(1'b0, 1'b0, -1, -1, -1);
        cmp_stream("plain", 1);
        check("plain_en_low",    32'(en_low),     32'd2);
        check("plain_loaded_at", 32'(loaded_at),  32'd19);
        check("plain_busy",      32'(busy),       32'd0);
        check("plain_enable",    32'(fir_enable), 32'd1);

        // Back-pressure: ready pattern 1,0,0,1
        reload(1'b1, 1'b0, -1, -1, -1);
        cmp_stream("toggle", 1);
        check("toggle_loaded", 32'(loaded), 32'd1);

        // Write to addr 3 during the stream is dropped and flagged
        reload(1'b0, 1'b0, -1, 2, -1);
        cmp_stream("wrdrop", 1);
        check("wrdrop_wr_err", 32'(wr_err), 32'd1);

        // Same-cycle write to addr 0 and commit; commit clears wr_err and
        // the stream also confirms mem[3] kept its value
        exp_mem[0] = 16'h7FFF;
        reload(1'b0, 1'b1, -1, -1, -1);
        cmp_stream("wrcommit", 1);
        check("wrcommit_first",  32'(got_q.size() > 0 ? got_q[0] : 16'h0), 32'h7FFF);
        check("wrcommit_wr_err", 32'(wr_err),    32'd0);
        check("wrcommit_ld_at",  32'(loaded_at), 32'd19);

        // Commit at transfer 5 queues a second full reload
        reload(1'b0, 1'b0, 5, -1, -1);
        cmp_stream("pending", 2);
        check("pending_en_low",    32'(en_low),    32'd4);
        check("pending_loaded_at", 32'(loaded_at), 32'd37);

        // Reset at transfer 8, then restream the retained contents
        reload(1'b0, 1'b0, -1, -1, 8);
        check("abort_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < got_q.size() && i < 8; i++)
            check($sformatf("abort[%0d]", i), 32'(got_q[i]), 32'(exp_mem[i]));
        @(negedge clk);
        reload(1'b0, 1'b0, -1, -1, -1);
        cmp_stream("after_rst", 1);
        check("after_rst_en_low",    32'(en_low),    32'd2);
        check("after_rst_loaded_at", 32'(loaded_at), 32'd19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
